explosion_sprite_animator: RTL and testbench

//  Upstream feeder of the explosion colour palette. Plays a multi-frame explosion

---
 rtl/explosion_sprite_animator.sv | 144 ++++++++++++++
 tb/tb_explosion_sprite_animator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/explosion_sprite_animator.sv
// explosion_sprite_animator
//   Plays a multi-frame explosion sprite at a triggered screen position. For
//   every VGA pixel it produces a 4-bit palette index. Sprite pixels come from
//   an external synchronous ROM that holds all frames back to back.
//   Animation timing comes from frame_clk (VGA vsync).
//
// Ports
//   Clk        system / pixel-domain clock
//   Reset      asynchronous, active-high reset
//   frame_clk  vsync level input; a rising edge marks a new video frame
//   trigger    1-cycle pulse that starts or restarts the explosion
//   trig_x/y   sprite top-left corner, sampled while trigger=1
//   DrawX/Y    current pixel coordinate from the VGA controller
//   rom_addr   sprite ROM address (combinational from DrawX/DrawY)
//   rom_data   ROM palette index, valid one Clk after rom_addr
//   pixel_idx  palette index, or TRANSP when the pixel is outside the sprite
//   pixel_on   the pixel is inside the sprite and not transparent
//   busy       the animation is playing
//
// State | meaning
// IDLE  | no explosion on screen; frame_clk edges are ignored
// PLAY  | sprite drawn at pos; frame_clk edges advance hold/frame counters

module explosion_sprite_animator #(
  parameter int          SPR_W      = 32,
  parameter int          SPR_H      = 32,
  parameter int          NUM_FRAMES = 8,
  parameter int          FRAME_HOLD = 4,
  parameter int          ADDR_W     = 13,
  parameter logic [3:0]  TRANSP     = 4'hF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              trigger,
  input  logic [9:0]        trig_x,
  input  logic [9:0]        trig_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pixel_idx,
  output logic              pixel_on,
  output logic              busy
);

  localparam int XW      = $clog2(SPR_W);
  localparam int YW      = $clog2(SPR_H);
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [9:0]         pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic               hit_q, hit_d;
  logic               fc_q, fc_d;

  logic               fc_edge;
  logic               in_x, in_y;
  logic [XW-1:0]      off_x;
  logic [YW-1:0]      off_y;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      hit_q   <= 1'b0;
      // Reset high so a frame_clk already high at release is not seen as an edge.
      fc_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      hit_q   <= hit_d;
      fc_q    <= fc_d;
    end
  end

  assign fc_d    = frame_clk;
  assign fc_edge = frame_clk & ~fc_q;

  // Next-state logic. A trigger always wins over a coincident frame_clk edge.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;

    if (trigger) begin
      state_d = ST_PLAY;
      frame_d = '0;
      hold_d  = '0;
      pos_x_d = trig_x;
      pos_y_d = trig_y;
    end else if (state_q == ST_PLAY && fc_edge) begin
      if (hold_q != HOLD_W'(FRAME_HOLD - 1)) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = '0;
        if (frame_q == FRAME_W'(NUM_FRAMES - 1)) begin
          state_d = ST_IDLE;
          frame_d = '0;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
    end
  end

  // Bounds are compared in 11 bits so a sprite near the right/bottom edge
  // clips instead of wrapping around to the left/top of the screen.
  always_comb begin
    in_x = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
           ({1'b0, DrawX} <  ({1'b0, pos_x_q} + 11'(SPR_W)));
    in_y = ({1'b0, DrawY} >= {1'b0, pos_y_q}) &&
           ({1'b0, DrawY} <  ({1'b0, pos_y_q} + 11'(SPR_H)));
    hit_d = (state_q == ST_PLAY) && in_x && in_y;
  end

  assign off_x = XW'(DrawX - pos_x_q);
  assign off_y = YW'(DrawY - pos_y_q);

  // SPR_W and SPR_H are powers of two, so frame*W*H + y*W + x is a plain concat.
  assign rom_addr = hit_d ? ADDR_W'({frame_q, off_y, off_x}) : '0;

  // hit_q lines up with the ROM's one-cycle read latency.
  assign pixel_idx = hit_q ? rom_data : TRANSP;
  assign pixel_on  = hit_q && (rom_data != TRANSP);
  assign busy      = (state_q == ST_PLAY);

endmodule

// File: tb/tb_explosion_sprite_animator.sv
module tb_explosion_sprite_animator;

  localparam int SPR   = 32;
  localparam int NF    = 8;
  localparam int FH    = 4;
  localparam int TOTAL = NF * FH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_clk = 1'b1;
  logic        trigger = 1'b0;
  logic [9:0]  trig_x = '0, trig_y = '0, draw_x = '0, draw_y = '0;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic [3:0]  pixel_idx;
  logic        pixel_on, busy;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b1;
  bit rand_en = 1'b0;

  // Reference model: count of frame_clk edges since the last trigger.
  bit m_play = 1'b0;
  int m_edges = 0;
  int m_px = 0, m_py = 0;
  bit m_fc_prev = 1'b1;
  bit m_hit_prev = 1'b0;
  int m_addr_prev = 0;

  explosion_sprite_animator dut (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .trigger(trigger),
    .trig_x(trig_x), .trig_y(trig_y), .DrawX(draw_x), .DrawY(draw_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel_idx(pixel_idx),
    .pixel_on(pixel_on), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input int a);
    return 4'((a * 7 + 3) & 15);
  endfunction

  function automatic bit exp_hit();
    int x, y;
    x = int'(draw_x);
    y = int'(draw_y);
    return m_play && x >= m_px && x < m_px + SPR && y >= m_py && y < m_py + SPR;
  endfunction

  function automatic int exp_addr();
    if (!exp_hit()) return 0;
    return (m_edges / FH) * SPR * SPR + (int'(draw_y) - m_py) * SPR + (int'(draw_x) - m_px);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous ROM seen by the DUT.
  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play <= 1'b0; m_edges <= 0; m_px <= 0; m_py <= 0;
      m_fc_prev <= 1'b1; m_hit_prev <= 1'b0; m_addr_prev <= 0;
    end else begin
      m_fc_prev   <= frame_clk;
      m_hit_prev  <= exp_hit();
      m_addr_prev <= exp_addr();
      if (trigger) begin
        m_play <= 1'b1; m_edges <= 0; m_px <= int'(trig_x); m_py <= int'(trig_y);
      end else if (m_play && frame_clk && !m_fc_prev) begin
        if (m_edges + 1 == TOTAL) begin
          m_play <= 1'b0; m_edges <= 0;
        end else begin
          m_edges <= m_edges + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_play));
      check("rom_addr", 32'(rom_addr), 32'(exp_addr()));
      check("pixel_idx", 32'(pixel_idx), m_hit_prev ? 32'(rom_fn(m_addr_prev)) : 32'hF);
      check("pixel_on", 32'(pixel_on), 32'(m_hit_prev && rom_fn(m_addr_prev) != 4'hF));
    end
  end

  task automatic step();
    if (rand_en) begin
      if ($urandom_range(0, 3) == 0) begin
        draw_x = 10'($urandom_range(0, 1023));
        draw_y = 10'($urandom_range(0, 1023));
      end else begin
        draw_x = 10'(m_px + int'($urandom_range(0, 47)) - 8);
        draw_y = 10'(m_py + int'($urandom_range(0, 47)) - 8);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fc_pulse();
    frame_clk = 1'b1; step(); step();
    frame_clk = 1'b0; step(); step();
  endtask

  task automatic fire(input int x, input int y);
    trig_x = 10'(x); trig_y = 10'(y); trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with frame_clk high.
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(pixel_idx), 32'hF);
    check("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_on", 32'(pixel_on), 32'd0);
    check("idle_idx", 32'(pixel_idx), 32'hF);

    // Trigger at (100,50) with the pixel at the corner.
    frame_clk = 1'b0;
    draw_x = 10'd100; draw_y = 10'd50;
    trig_x = 10'd100; trig_y = 10'd50; trigger = 1'b1;
    #1 check("t2_addr_trig", 32'(rom_addr), 32'd0);
    step();
    trigger = 1'b0;
    #1 check("t2_busy", 32'(busy), 32'd1);
    check("t2_addr", 32'(rom_addr), 32'd0);
    step();
    check("t2_on", 32'(pixel_on), 32'd1);
    check("t2_idx", 32'(pixel_idx), 32'h3);

    // Bottom-right corner of the sprite, then one pixel past it.
    draw_x = 10'd131; draw_y = 10'd81;
    #1 check("t3_corner", 32'(rom_addr), 32'd1023);
    draw_x = 10'd132;
    #1 check("t3_outside", 32'(rom_addr), 32'd0);
    step();
    check("t3_off", 32'(pixel_on), 32'd0);

    // Frame advance and end of animation.
    draw_x = 10'd100; draw_y = 10'd50;
    repeat (4) fc_pulse();
    #1 check("t4_frame1", 32'(rom_addr), 32'd1024);
    repeat (28) fc_pulse();
    check("t4_done", 32'(busy), 32'd0);

    // Sprite at the bottom-right screen corner.
    fire(620, 470);
    draw_x = 10'd639; draw_y = 10'd479;
    #1 check("t5_edge", 32'(rom_addr), 32'd307);
    draw_x = 10'd0; draw_y = 10'd0;
    #1 check("t5_wrap", 32'(rom_addr), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);

    // Restart coinciding with a frame_clk edge at frame 5.
    fire(200, 100);
    draw_x = 10'd200; draw_y = 10'd100;
    repeat (23) fc_pulse();
    #1 check("t6_frame5", 32'(rom_addr), 32'd5120);
    frame_clk = 1'b1; trig_x = 10'd200; trig_y = 10'd100; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    frame_clk = 1'b0; step(); step();
    #1 check("t6_frame0", 32'(rom_addr), 32'd0);
    repeat (3) fc_pulse();
    #1 check("t6_hold0", 32'(rom_addr), 32'd0);
    fc_pulse();
    #1 check("t6_next", 32'(rom_addr), 32'd1024);

    // Asynchronous reset while playing.
    rst = 1'b1;
    #1 check("async_busy", 32'(busy), 32'd0);
    check("async_addr", 32'(rom_addr), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Randomized phase.
    rand_en = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 99) == 0) begin
        trigger = 1'b1;
        trig_x = 10'($urandom_range(0, 1023));
        trig_y = 10'($urandom_range(0, 1023));
      end else begin
        trigger = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      step();
    end
    trigger = 1'b0;
    rand_en = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
